gpio_irq: RTL and testbench

GPIO_IRQ -- requirements
Module: gpio_irq

---
 rtl/gpio_pkg.sv | 13 +
 rtl/gpio_filter_bit.sv | 51 +++++
 rtl/gpio_irq.sv | 97 +++++++++
 tb/tb_gpio_irq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO interrupt block: register map and filter default.
package gpio_pkg;

    localparam int FILT_CYCLES_DEF = 4;

    localparam logic [2:0] ADDR_MASK = 3'd0;
    localparam logic [2:0] ADDR_RISE = 3'd1;
    localparam logic [2:0] ADDR_FALL = 3'd2;
    localparam logic [2:0] ADDR_PEND = 3'd3;
    localparam logic [2:0] ADDR_PIN  = 3'd4;
    localparam logic [2:0] ADDR_FILT = 3'd5;

endpackage

// File: rtl/gpio_filter_bit.sv
// One GPIO input: 2-flop synchronizer followed by an optional stability filter.
module gpio_filter_bit
    import gpio_pkg::*;
#(
    parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
    input  logic clock,
    input  logic resetn,
    input  logic pin,
    input  logic en,
    output logic filt
);

    localparam logic [3:0] CNT_LAST = 4'(FILT_CYCLES - 1);

    logic       sync1;
    logic       sync2;
    logic [3:0] cnt;
    logic       en_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            filt  <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            en_q  <= en;
            // A change of the enable restarts the count and holds filt for that cycle.
            if (en != en_q) begin
                cnt <= '0;
            end else if (!en) begin
                cnt  <= '0;
                filt <= sync2;
            end else if (sync2 != filt) begin
                if (cnt == CNT_LAST) begin
                    filt <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gpio_irq.sv
// Avalon-MM GPIO input block with per-bit filtering, edge detection and a level interrupt.
module gpio_irq
    import gpio_pkg::*;
#(
    parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    input  logic        write,
    input  logic        read,
    input  logic        chipselect,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic [31:0] pin_in,
    output logic        irq
);

    logic [31:0] mask;
    logic [31:0] rise_en;
    logic [31:0] fall_en;
    logic [31:0] pend;
    logic [31:0] filt_en;
    logic [31:0] filt;
    logic [31:0] prev;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] set_evt;
    logic [31:0] w1c;
    logic        wr_en;
    logic        unused_read;

    // Reads are purely combinational on chipselect, so the read strobe carries no information.
    assign unused_read = read;
    assign waitrequest = 1'b0;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        gpio_filter_bit #(
            .FILT_CYCLES(FILT_CYCLES)
        ) u_filter (
            .clock (clock),
            .resetn(resetn),
            .pin   (pin_in[i]),
            .en    (filt_en[i]),
            .filt  (filt[i])
        );
    end

    assign wr_en   = write & chipselect;
    assign rise    = filt & ~prev;
    assign fall    = ~filt & prev;
    assign set_evt = mask & ((rise & rise_en) | (fall & fall_en));
    assign w1c     = (wr_en && address == ADDR_PEND) ? writedata : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mask    <= '0;
            rise_en <= '0;
            fall_en <= '0;
            filt_en <= '0;
            pend    <= '0;
            prev    <= '0;
        end else begin
            if (wr_en) begin
                case (address)
                    ADDR_MASK: mask    <= writedata;
                    ADDR_RISE: rise_en <= writedata;
                    ADDR_FALL: fall_en <= writedata;
                    ADDR_FILT: filt_en <= writedata;
                    default:   ;
                endcase
            end
            prev <= filt;
            // A new event on the same edge as a clear keeps the bit pending.
            pend <= (pend & ~w1c) | set_evt;
        end
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                ADDR_MASK: readdata = mask;
                ADDR_RISE: readdata = rise_en;
                ADDR_FALL: readdata = fall_en;
                ADDR_PEND: readdata = pend;
                ADDR_PIN:  readdata = filt;
                ADDR_FILT: readdata = filt_en;
                default:   readdata = '0;
            endcase
        end
    end

    assign irq = |(pend & mask);

endmodule

// File: tb/tb_gpio_irq.sv
// Scoreboard bench for gpio_irq: expected values queued with stimulus, popped on each sample.
module tb_gpio_irq;

    logic        clock = 1'b0;
    logic        resetn;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic        write;
    logic        read;
    logic        chipselect;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] pin_in;
    logic        irq;

    logic [31:0] sb_q[$];
    int          total = 0;
    int          bad   = 0;

    gpio_irq #(.FILT_CYCLES(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .address    (address),
        .writedata  (writedata),
        .write      (write),
        .read       (read),
        .chipselect (chipselect),
        .readdata   (readdata),
        .waitrequest(waitrequest),
        .pin_in     (pin_in),
        .irq        (irq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [31:0] got);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got=0x%08h expected=<empty scoreboard>", tag, got);
        end else begin
            exp = sb_q.pop_front();
            chk(tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        @(negedge clock);
        write      = 1'b0;
        chipselect = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        sb_q.push_back(exp);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        #1;
        sb_check(tag, readdata);
        read       = 1'b0;
        chipselect = 1'b0;
    endtask

    task automatic rd_nocs(input string tag, input logic [2:0] a, input logic [31:0] exp);
        sb_q.push_back(exp);
        address    = a;
        chipselect = 1'b0;
        read       = 1'b1;
        #1;
        sb_check(tag, readdata);
        read       = 1'b0;
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        sb_q.push_back({31'b0, exp});
        sb_check(tag, {31'b0, irq});
    endtask

    initial begin
        resetn = 1'b0; address = '0; writedata = '0; write = 1'b0;
        read = 1'b0; chipselect = 1'b0; pin_in = '0;

        // Reset state
        tick(2);
        for (int a = 0; a < 8; a++) rd($sformatf("rst_rd%0d", a), 3'(a), 32'h0);
        chk_irq("rst_irq", 1'b0);
        chk("waitreq", {31'b0, waitrequest}, 32'h0);
        @(negedge clock);
        resetn = 1'b1;
        tick(2);

        // Unfiltered rising edge on pin0, PEND appears after edge k+3
        wr(3'd0, 32'h1);
        wr(3'd1, 32'h1);
        rd("mask_rb", 3'd0, 32'h1);
        pin_in[0] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            rd($sformatf("lat_pend_e%0d", i - 1), 3'd3, (i == 4) ? 32'h1 : 32'h0);
            chk_irq($sformatf("lat_irq_e%0d", i - 1), i == 4);
        end

        // W1C, mask gating and set-wins-over-clear
        wr(3'd0, 32'h3);
        wr(3'd1, 32'h3);
        pin_in[1] = 1'b1;
        tick(4);
        rd("pend_both", 3'd3, 32'h3);
        wr(3'd3, 32'h1);
        rd("w1c_bit0", 3'd3, 32'h2);
        chk_irq("w1c_irq", 1'b1);
        wr(3'd0, 32'h1);
        rd("mask_keep_pend", 3'd3, 32'h2);
        chk_irq("mask_irq_off", 1'b0);
        wr(3'd0, 32'h3);
        chk_irq("mask_irq_on", 1'b1);
        pin_in[1] = 1'b0;
        tick(4);
        pin_in[1] = 1'b1;
        tick(3);
        wr(3'd3, 32'h2);
        rd("set_wins", 3'd3, 32'h2);
        wr(3'd3, 32'h2);
        rd("w1c_bit1", 3'd3, 32'h0);
        chk_irq("w1c_irq_off", 1'b0);

        // All pins rise with MASK=0
        wr(3'd0, 32'h0);
        pin_in = '0;
        tick(4);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd1, 32'hFFFF_FFFF);
        pin_in = 32'hFFFF_FFFF;
        tick(2);
        rd("pin_early", 3'd4, 32'h0);
        tick(1);
        rd("pin_all", 3'd4, 32'hFFFF_FFFF);
        tick(3);
        rd("masked_pend", 3'd3, 32'h0);
        chk_irq("masked_irq", 1'b0);

        // Filtered falling edge on pin1
        wr(3'd1, 32'h0);
        wr(3'd5, 32'h2);
        wr(3'd2, 32'h2);
        wr(3'd0, 32'h2);
        wr(3'd3, 32'hFFFF_FFFF);
        tick(2);
        pin_in[1] = 1'b0;
        tick(3);
        pin_in[1] = 1'b1;
        tick(8);
        rd("glitch_pend", 3'd3, 32'h0);
        rd("glitch_pin", 3'd4, 32'hFFFF_FFFF);
        pin_in[1] = 1'b0;
        tick(5);
        rd("filt_pin_e4", 3'd4, 32'hFFFF_FFFF);
        tick(1);
        rd("filt_pin_e5", 3'd4, 32'hFFFF_FFFD);
        rd("filt_pend_e5", 3'd3, 32'h0);
        tick(1);
        rd("filt_pend_e6", 3'd3, 32'h2);
        chk_irq("filt_irq", 1'b1);

        // Reserved addresses, read-only PIN, chipselect low
        rd("rsv6", 3'd6, 32'h0);
        rd("rsv7", 3'd7, 32'h0);
        wr(3'd4, 32'h0000_FFFF);
        rd("pin_ro", 3'd4, 32'hFFFF_FFFD);
        wr(3'd6, 32'h0000_00FF);
        rd("mask_after_rsv", 3'd0, 32'h2);
        rd_nocs("cs_low", 3'd0, 32'h0);

        // Reset mid-filter-count, pin0 held high through release
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd5, 32'h1);
        wr(3'd0, 32'h1);
        wr(3'd1, 32'h1);
        pin_in[0] = 1'b0;
        tick(3);
        resetn = 1'b0;
        #1;
        for (int a = 0; a < 6; a++) rd($sformatf("mid_rst_rd%0d", a), 3'(a), 32'h0);
        chk_irq("mid_rst_irq", 1'b0);
        pin_in[0] = 1'b1;
        @(negedge clock);
        resetn = 1'b1;
        wr(3'd0, 32'h1);
        wr(3'd1, 32'h1);
        tick(1);
        rd("post_rst_pend_e2", 3'd3, 32'h0);
        tick(1);
        rd("post_rst_pend_e3", 3'd3, 32'h1);
        chk_irq("post_rst_irq", 1'b1);
        rd("post_rst_pin", 3'd4, 32'hFFFF_FFFD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
